// File: rtl/nco_sweep_ctrl.sv
// Stepped-frequency sweep sequencer for the NCO frequency-control word.
// Latches a sweep configuration on start and walks IDLE -> PRIME -> DWELL -> DONE.
module nco_sweep_ctrl #(
    parameter int DWELL_WIDTH = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   ipClk,
    input  logic                   ipReset,
    input  logic                   ipStart,
    input  logic                   ipAbort,
    input  logic [31:0]            ipStartFreq,
    input  logic [31:0]            ipStepFreq,
    input  logic [COUNT_WIDTH-1:0] ipNumSteps,
    input  logic [DWELL_WIDTH-1:0] ipDwell,
    input  logic                   ipContinuous,
    output logic [31:0]            opFrequency,
    output logic                   opNcoReset,
    output logic                   opBusy,
    output logic                   opStepStrobe,
    output logic                   opDone,
    output logic [1:0]             opState
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PRIME = 2'd1;
    localparam logic [1:0] DWELL = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]             state;
    logic [31:0]            start_word;
    logic [31:0]            step_word;
    logic [COUNT_WIDTH-1:0] num_steps;
    logic [DWELL_WIDTH-1:0] dwell_len;
    logic                   continuous;
    logic [COUNT_WIDTH-1:0] step_idx;
    logic [DWELL_WIDTH-1:0] dwell_cnt;
    logic                   last_step;
    logic                   dwell_expired;

    assign opState       = state;
    assign last_step     = (step_idx == num_steps - COUNT_WIDTH'(1));
    assign dwell_expired = (dwell_cnt == DWELL_WIDTH'(1));

    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            state        <= IDLE;
            start_word   <= '0;
            step_word    <= '0;
            num_steps    <= '0;
            dwell_len    <= '0;
            continuous   <= 1'b0;
            step_idx     <= '0;
            dwell_cnt    <= '0;
            opFrequency  <= '0;
            opNcoReset   <= 1'b1;
            opBusy       <= 1'b0;
            opStepStrobe <= 1'b0;
            opDone       <= 1'b0;
        end else begin
            opStepStrobe <= 1'b0;
            opDone       <= 1'b0;
            case (state)
                IDLE: begin
                    opNcoReset  <= 1'b1;
                    opFrequency <= '0;
                    opBusy      <= 1'b0;
                    if (ipStart) begin
                        start_word <= ipStartFreq;
                        step_word  <= ipStepFreq;
                        num_steps  <= ipNumSteps;
                        dwell_len  <= (ipDwell == '0) ? DWELL_WIDTH'(1) : ipDwell;
                        continuous <= ipContinuous;
                        if (ipNumSteps == '0) begin
                            state  <= DONE;
                            opDone <= 1'b1;
                        end else begin
                            state       <= PRIME;
                            opFrequency <= ipStartFreq;
                            opBusy      <= 1'b1;
                        end
                    end
                end
                PRIME: begin
                    if (ipAbort) begin
                        state       <= IDLE;
                        opFrequency <= '0;
                        opNcoReset  <= 1'b1;
                        opBusy      <= 1'b0;
                    end else begin
                        state      <= DWELL;
                        opNcoReset <= 1'b0;
                        step_idx   <= '0;
                        dwell_cnt  <= dwell_len;
                    end
                end
                DWELL: begin
                    // Abort outranks both a step and a completion on the same cycle.
                    if (ipAbort) begin
                        state       <= IDLE;
                        opFrequency <= '0;
                        opNcoReset  <= 1'b1;
                        opBusy      <= 1'b0;
                    end else if (!dwell_expired) begin
                        dwell_cnt <= dwell_cnt - DWELL_WIDTH'(1);
                    end else if (!last_step) begin
                        opFrequency  <= opFrequency + step_word;
                        step_idx     <= step_idx + COUNT_WIDTH'(1);
                        dwell_cnt    <= dwell_len;
                        opStepStrobe <= 1'b1;
                    end else if (continuous) begin
                        // Phase-continuous wrap: the NCO is not reset between passes.
                        opFrequency  <= start_word;
                        step_idx     <= '0;
                        dwell_cnt    <= dwell_len;
                        opStepStrobe <= 1'b1;
                    end else begin
                        state       <= DONE;
                        opDone      <= 1'b1;
                        opBusy      <= 1'b0;
                        opNcoReset  <= 1'b1;
                        opFrequency <= '0;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    opFrequency <= '0;
                    opNcoReset  <= 1'b1;
                    opBusy      <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: directed and randomized sweeps checked cycle by cycle
// against a closed-form model of the expected output trace.
module tb_nco_sweep_ctrl;

    logic        ipClk = 1'b0;
    logic        ipReset = 1'b1;
    logic        ipStart = 1'b0;
    logic        ipAbort = 1'b0;
    logic [31:0] ipStartFreq = '0;
    logic [31:0] ipStepFreq = '0;
    logic [15:0] ipNumSteps = '0;
    logic [15:0] ipDwell = '0;
    logic        ipContinuous = 1'b0;
    logic [31:0] opFrequency;
    logic        opNcoReset;
    logic        opBusy;
    logic        opStepStrobe;
    logic        opDone;
    logic [1:0]  opState;

    int total = 0;
    int bad = 0;

    nco_sweep_ctrl #(.DWELL_WIDTH(16), .COUNT_WIDTH(16)) dut (
        .ipClk(ipClk),
        .ipReset(ipReset),
        .ipStart(ipStart),
        .ipAbort(ipAbort),
        .ipStartFreq(ipStartFreq),
        .ipStepFreq(ipStepFreq),
        .ipNumSteps(ipNumSteps),
        .ipDwell(ipDwell),
        .ipContinuous(ipContinuous),
        .opFrequency(opFrequency),
        .opNcoReset(opNcoReset),
        .opBusy(opBusy),
        .opStepStrobe(opStepStrobe),
        .opDone(opDone),
        .opState(opState)
    );

    always #5 ipClk = ~ipClk;

    // Expected outputs k cycles after the start request, derived from the sweep timeline:
    // k=1 prime, k=2..1+N*D dwell steps, k=2+N*D done pulse, idle afterwards or after an abort.
    function automatic void model(input int k, input logic [31:0] sf, input logic [31:0] st,
                                  input int n, input int d, input logic cont, input int abort_at,
                                  output logic [31:0] f, output logic nr, output logic b,
                                  output logic s, output logic dn);
        int s_abs;
        f = 32'd0; nr = 1'b1; b = 1'b0; s = 1'b0; dn = 1'b0;
        if (abort_at > 0 && k > abort_at) return;
        if (n == 0) begin
            dn = (k == 1);
            return;
        end
        if (k == 1) begin
            f = sf; b = 1'b1;
        end else if (cont || k <= 1 + n * d) begin
            s_abs = (k - 2) / d;
            f = sf + 32'(s_abs % n) * st;
            nr = 1'b0; b = 1'b1;
            s = (k > 2) && ((k - 2) % d == 0);
        end else if (k == 2 + n * d) begin
            dn = 1'b1;
        end
    endfunction

    task automatic run_sweep(input string name, input logic [31:0] sf, input logic [31:0] st,
                             input int n, input int dwell_in, input logic cont,
                             input int abort_at, input int cycles, input logic noise,
                             input logic start_abort);
        int d;
        int last_busy;
        logic [31:0] ef;
        logic enr, eb, es, edn;
        d = (dwell_in == 0) ? 1 : dwell_in;
        if (n == 0) last_busy = 1;
        else if (abort_at > 0) last_busy = (abort_at < 2 + n * d) ? abort_at : 2 + n * d;
        else if (cont) last_busy = cycles;
        else last_busy = 2 + n * d;
        @(posedge ipClk); #1;
        ipStartFreq = sf; ipStepFreq = st; ipNumSteps = 16'(n);
        ipDwell = 16'(dwell_in); ipContinuous = cont;
        ipStart = 1'b1; ipAbort = start_abort;
        for (int k = 1; k <= cycles; k++) begin
            @(posedge ipClk); #1;
            ipStart = 1'b0;
            ipAbort = (k == abort_at);
            if (noise) begin
                ipStartFreq = $urandom; ipStepFreq = $urandom;
                ipNumSteps = 16'($urandom_range(0, 5)); ipDwell = 16'($urandom_range(0, 4));
                ipContinuous = 1'($urandom_range(0, 1));
                ipStart = (k <= last_busy) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            model(k, sf, st, n, d, cont, abort_at, ef, enr, eb, es, edn);
            total += 5;
            if (opFrequency !== ef) begin
                bad++; $display("FAIL %s freq k=%0d got=%h exp=%h", name, k, opFrequency, ef);
            end
            if (opNcoReset !== enr) begin
                bad++; $display("FAIL %s nco_reset k=%0d got=%b exp=%b", name, k, opNcoReset, enr);
            end
            if (opBusy !== eb) begin
                bad++; $display("FAIL %s busy k=%0d got=%b exp=%b", name, k, opBusy, eb);
            end
            if (opStepStrobe !== es) begin
                bad++; $display("FAIL %s strobe k=%0d got=%b exp=%b", name, k, opStepStrobe, es);
            end
            if (opDone !== edn) begin
                bad++; $display("FAIL %s done k=%0d got=%b exp=%b", name, k, opDone, edn);
            end
        end
        ipStart = 1'b0; ipAbort = 1'b0;
    endtask

    task automatic check_idle_outputs(input string name);
        total += 5;
        if (opFrequency !== 32'd0) begin bad++; $display("FAIL %s freq got=%h exp=0", name, opFrequency); end
        if (opNcoReset !== 1'b1) begin bad++; $display("FAIL %s nco_reset got=%b exp=1", name, opNcoReset); end
        if (opBusy !== 1'b0) begin bad++; $display("FAIL %s busy got=%b exp=0", name, opBusy); end
        if (opStepStrobe !== 1'b0) begin bad++; $display("FAIL %s strobe got=%b exp=0", name, opStepStrobe); end
        if (opDone !== 1'b0) begin bad++; $display("FAIL %s done got=%b exp=0", name, opDone); end
    endtask

    task automatic test_reset();
        #12;
        check_idle_outputs("reset_hold");
        @(negedge ipClk);
        ipReset = 1'b0;
        @(posedge ipClk); #1;
        check_idle_outputs("reset_release");
    endtask

    task automatic test_basic_sweep();
        run_sweep("basic", 32'h0100_0000, 32'h0010_0000, 4, 3, 1'b0, 0, 16, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        run_sweep("wrap", 32'hFFF0_0000, 32'h0020_0000, 2, 0, 1'b0, 0, 6, 1'b0, 1'b0);
        run_sweep("dwell1", 32'h1234_5678, 32'hFFFF_FFF0, 3, 1, 1'b0, 0, 7, 1'b0, 1'b0);
    endtask

    task automatic test_continuous_abort();
        int a;
        a = $urandom_range(6, 20);
        run_sweep("cont_abort", 32'h0000_1000, 32'h0000_0010, 2, 2, 1'b1, a, a + 3, 1'b0, 1'b0);
        run_sweep("cont_n1", 32'hABCD_0000, 32'h0000_0001, 1, 3, 1'b1, 14, 16, 1'b0, 1'b0);
    endtask

    task automatic test_zero_steps_and_noise();
        run_sweep("zero_steps", 32'h5555_0000, 32'h1, 0, 3, 1'b0, 0, 4, 1'b0, 1'b0);
        run_sweep("noise", 32'h0200_0000, 32'h0000_0100, 4, 2, 1'b0, 0, 12, 1'b1, 1'b0);
    endtask

    task automatic test_abort_edges();
        run_sweep("abort_final", 32'h0300_0000, 32'h0000_1000, 3, 2, 1'b0, 7, 10, 1'b0, 1'b0);
        run_sweep("abort_prime", 32'h0300_0000, 32'h0000_1000, 3, 2, 1'b0, 1, 4, 1'b0, 1'b0);
        run_sweep("start_abort", 32'h0400_0000, 32'h0000_0800, 2, 2, 1'b0, 0, 8, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            int n, dw, a, len;
            logic cont;
            n = $urandom_range(0, 5);
            dw = $urandom_range(0, 4);
            cont = 1'($urandom_range(0, 1));
            len = cont ? 30 : 3 + n * ((dw == 0) ? 1 : dw) + 2;
            a = (cont || $urandom_range(0, 1) == 1) ? $urandom_range(1, len - 2) : 0;
            run_sweep("random", $urandom, $urandom, n, dw, cont, a, len, 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic test_async_reset_mid_dwell();
        @(posedge ipClk); #1;
        ipStartFreq = 32'h0700_0000; ipStepFreq = 32'h10; ipNumSteps = 16'd5;
        ipDwell = 16'd4; ipContinuous = 1'b0; ipStart = 1'b1;
        @(posedge ipClk); #1;
        ipStart = 1'b0;
        repeat (4) @(posedge ipClk);
        #3 ipReset = 1'b1;
        #1;
        check_idle_outputs("async_reset");
        @(posedge ipClk); #2;
        ipReset = 1'b0;
        @(posedge ipClk); #1;
        check_idle_outputs("after_async_reset");
        @(posedge ipClk); #1;
        check_idle_outputs("idle_stays");
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_wrap();
        test_continuous_abort();
        test_zero_steps_and_noise();
        test_abort_edges();
        test_random();
        test_async_reset_mid_dwell();
        run_sweep("post_reset", 32'h0100_0000, 32'h0010_0000, 2, 2, 1'b0, 0, 8, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
